lcd_frame_scheduler: RTL and testbench
======================================

// Module: lcd_frame_scheduler
// PURPOSE
//  Sequences LCD refresh after panel init: background redraw (lcd_show_pic), then
//  hand-line overlay (draw_line), one phase at a time on the shared lcd_write SPI path.
//  Starts frames only when ball/hand coordinates change, limited to one per FRAME_DIV cycles.
//  Latches coordinates so they stay stable for a whole frame.
//  Adds a per-phase watchdog so a lost done pulse cannot hang the display.
// PARAMETERS
//  COORD_W     9           width of ball_y / hand_x and latched copies
//  FRAME_DIV   1_666_666   min cycles between frame starts (30 fps @ 50 MHz), >=2
//  TIMEOUT_CYC 25_000_000  max cycles per phase before abort (0.5 s), >=2
// PORTS
//  sys_clk_50MHz   in   1        system clock, 50 MHz
//  sys_rst_n       in   1        asynchronous active-low reset
//  init_done       in   1        level from lcd_init; 1 = panel ready
//  ball_y          in   COORD_W  live ball Y (picture offset)
//  hand_x          in   COORD_W  live hand X (line position)
//  show_pic_done   in   1        1-cycle pulse, background redraw finished
//  draw_line_done  in   1        1-cycle pulse, line overlay finished
//  show_pic_flag   out  1        level, request background redraw
//  draw_line_flag  out  1        level, request line overlay
//  offset_lat      out  COORD_W  ball_y latched at frame start; drives pic_ram offset
//  coord_lat       out  COORD_W  hand_x latched at frame start; drives draw_line y_coord
//  busy            out  1        1 in PIC or LINE
//  frame_cnt       out  16       completed frames, wraps 0xFFFF->0
//  timeout_err     out  1        sticky watchdog flag; cleared only by reset
// BEHAVIOUR
//  Reset: state=WAIT_INIT. All outputs 0. dirty=1, rate_cnt=0, tick=0, wdog=0.
//  States: WAIT_INIT, IDLE, PIC, LINE.
//  Rate counter: runs in every state except WAIT_INIT.
//   At FRAME_DIV-1 it sets tick and holds there; frame start clears both counter and tick.
//  dirty: set any cycle (ball_y,hand_x) != (offset_lat,coord_lat) in IDLE/PIC/LINE.
//   Cleared at frame start, but set again that same cycle if the inputs still differ.
//  WAIT_INIT -> IDLE when init_done=1.
//   On entry to IDLE from WAIT_INIT: tick=1, dirty=1, so the first frame is immediate.
//  IDLE -> PIC when tick & dirty (frame start). Same edge:
//   - offset_lat<=ball_y, coord_lat<=hand_x
//   - show_pic_flag<=1, wdog<=0
//  PIC: hold show_pic_flag=1. On show_pic_done, next edge:
//   - show_pic_flag<=0, draw_line_flag<=1, wdog<=0; -> LINE
//  LINE: hold draw_line_flag=1. On draw_line_done, next edge:
//   - draw_line_flag<=0, frame_cnt+1; -> IDLE
//  Flags are mutually exclusive and never both 1. Each phase ends at most 1 cycle after its done pulse.
//  Watchdog: wdog counts in PIC/LINE. Reaching TIMEOUT_CYC-1 with no done pulse that cycle:
//   - drop the flag, timeout_err<=1, dirty<=1, -> IDLE; frame_cnt unchanged
//   - the retry starts at the next tick
//  Done and timeout in the same cycle: done wins, normal advance.
//  Done pulse in a non-matching state (e.g. draw_line_done in PIC, any done in IDLE): ignored.
//  init_done falls in any state: next edge -> WAIT_INIT.
//   - flags and busy <=0, rate_cnt and tick <=0, dirty<=1
//   - frame_cnt, latches and timeout_err are kept
//  Coordinate changes during PIC/LINE never alter the latches. They set dirty, which causes one follow-up frame.
//  Async reset mid-frame: outputs 0 immediately, no handshake with downstream.
//  frame_cnt wraps without saturation. Counter widths: ceil(log2(param)) bits, no overflow.
// TESTING  (FRAME_DIV=100, TIMEOUT_CYC=1000)
//  Startup: init_done 0->1, ball_y=5, hand_x=7 -> show_pic_flag=1 one edge later; offset_lat=5, coord_lat=7.
//  Done in PIC: show_pic_done pulse -> next edge show_pic_flag=0, draw_line_flag=1.
//   Then draw_line_done -> flags 0, frame_cnt=1, busy=0.
//  Static coords: no input change for 1000 cycles after frame 1 -> no new flag, frame_cnt stays 1.
//  Rate limit: hand_x=20 at cycle 10 after frame-1 start -> next show_pic_flag exactly 100 cycles after frame-1 start.
//   coord_lat=20 at that point.
//  Timeout: no show_pic_done for 1000 cycles -> flag drops, timeout_err=1, frame_cnt unchanged.
//   Retry show_pic_flag follows at the next tick.
//  Init loss: init_done->0 in LINE with frame_cnt=3 -> next edge state WAIT_INIT, flags 0, frame_cnt=3.
//   init_done back to 1 -> immediate new frame.

Source files
------------

// File: rtl/lcd_frame_scheduler.sv
// LCD refresh sequencer: change-driven, rate-limited frames made of a background
// redraw phase followed by a line-overlay phase, each guarded by a watchdog.
`timescale 1ns/1ps

module lcd_frame_scheduler #(
  parameter int COORD_W     = 9,
  parameter int FRAME_DIV   = 1_666_666,
  parameter int TIMEOUT_CYC = 25_000_000
) (
  input  logic               sys_clk_50MHz,
  input  logic               sys_rst_n,
  input  logic               init_done,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] hand_x,
  input  logic               show_pic_done,
  input  logic               draw_line_done,
  output logic               show_pic_flag,
  output logic               draw_line_flag,
  output logic [COORD_W-1:0] offset_lat,
  output logic [COORD_W-1:0] coord_lat,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic               timeout_err
);

  localparam int RATE_W = $clog2(FRAME_DIV);
  localparam int WDOG_W = $clog2(TIMEOUT_CYC);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(FRAME_DIV - 1);
  localparam logic [RATE_W-1:0] RATE_PRE  = RATE_W'(FRAME_DIV - 2);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_IDLE      = 2'd1,
    S_PIC       = 2'd2,
    S_LINE      = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_show_pic_flag;
  logic               r_draw_line_flag;
  logic [COORD_W-1:0] r_offset_lat;
  logic [COORD_W-1:0] r_coord_lat;
  logic               r_busy;
  logic [15:0]        r_frame_cnt;
  logic               r_timeout_err;
  logic               r_dirty;
  logic [RATE_W-1:0]  r_rate_cnt;
  logic               r_tick;
  logic [WDOG_W-1:0]  r_wdog;

  logic w_coord_diff;
  logic w_wdog_exp;
  logic w_frame_start;
  logic w_pic_end;
  logic w_line_end;
  logic w_timeout;
  logic w_init_loss;

  assign w_coord_diff = (ball_y != r_offset_lat) || (hand_x != r_coord_lat);
  assign w_wdog_exp   = (r_wdog == WDOG_LAST);

  // Loss of init_done outranks everything; a done pulse outranks a same-cycle timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_pic_end     = 1'b0;
    w_line_end    = 1'b0;
    w_timeout     = 1'b0;
    w_init_loss   = 1'b0;
    case (r_state)
      S_WAIT_INIT: begin
        if (init_done) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_WAIT_INIT;
      end
      S_IDLE: begin
        if (!init_done) begin
          w_init_loss = 1'b1;
          w_state_nxt = S_WAIT_INIT;
        end else if (r_tick && r_dirty) begin
          w_frame_start = 1'b1;
          w_state_nxt   = S_PIC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PIC: begin
        if (!init_done) begin
          w_init_loss = 1'b1;
          w_state_nxt = S_WAIT_INIT;
        end else if (show_pic_done) begin
          w_pic_end   = 1'b1;
          w_state_nxt = S_LINE;
        end else if (w_wdog_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_PIC;
        end
      end
      S_LINE: begin
        if (!init_done) begin
          w_init_loss = 1'b1;
          w_state_nxt = S_WAIT_INIT;
        end else if (draw_line_done) begin
          w_line_end  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_wdog_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LINE;
        end
      end
      default: w_state_nxt = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_WAIT_INIT;
    else            r_state <= w_state_nxt;
  end

  // Flags follow the next state so they change on the same edge as the phase.
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_show_pic_flag  <= 1'b0;
      r_draw_line_flag <= 1'b0;
      r_busy           <= 1'b0;
      r_offset_lat     <= {COORD_W{1'b0}};
      r_coord_lat      <= {COORD_W{1'b0}};
      r_frame_cnt      <= 16'd0;
      r_timeout_err    <= 1'b0;
    end else begin
      r_show_pic_flag  <= (w_state_nxt == S_PIC);
      r_draw_line_flag <= (w_state_nxt == S_LINE);
      r_busy           <= (w_state_nxt == S_PIC) || (w_state_nxt == S_LINE);
      if (w_frame_start) begin
        r_offset_lat <= ball_y;
        r_coord_lat  <= hand_x;
      end
      if (w_line_end) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_timeout)  r_timeout_err <= 1'b1;
    end
  end

  // Rate limiter: tick rises together with the counter reaching its last value, so
  // frame starts are spaced by exactly FRAME_DIV cycles at minimum.
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rate_cnt <= {RATE_W{1'b0}};
      r_tick     <= 1'b0;
    end else if (w_init_loss) begin
      r_rate_cnt <= {RATE_W{1'b0}};
      r_tick     <= 1'b0;
    end else if (r_state == S_WAIT_INIT) begin
      r_rate_cnt <= {RATE_W{1'b0}};
      r_tick     <= init_done;
    end else if (w_frame_start) begin
      r_rate_cnt <= {RATE_W{1'b0}};
      r_tick     <= 1'b0;
    end else if (r_rate_cnt != RATE_LAST) begin
      r_rate_cnt <= r_rate_cnt + {{(RATE_W-1){1'b0}}, 1'b1};
      if (r_rate_cnt == RATE_PRE) r_tick <= 1'b1;
    end
  end

  // Dirty tracks any difference between live and latched coordinates since the last start.
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dirty <= 1'b1;
    end else if (w_init_loss || w_timeout || (r_state == S_WAIT_INIT)) begin
      r_dirty <= 1'b1;
    end else if (w_frame_start) begin
      r_dirty <= 1'b0;
    end else if (w_coord_diff) begin
      r_dirty <= 1'b1;
    end
  end

  // Per-phase watchdog, restarted at each phase entry and saturating at its limit.
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wdog <= {WDOG_W{1'b0}};
    end else if (w_frame_start || w_pic_end) begin
      r_wdog <= {WDOG_W{1'b0}};
    end else if (((r_state == S_PIC) || (r_state == S_LINE)) && !w_wdog_exp) begin
      r_wdog <= r_wdog + {{(WDOG_W-1){1'b0}}, 1'b1};
    end
  end

  assign show_pic_flag  = r_show_pic_flag;
  assign draw_line_flag = r_draw_line_flag;
  assign offset_lat     = r_offset_lat;
  assign coord_lat      = r_coord_lat;
  assign busy           = r_busy;
  assign frame_cnt      = r_frame_cnt;
  assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Scoreboard bench for lcd_frame_scheduler: a timestamp-based reference model predicts
// frame starts, phase changes, completions and timeouts; a monitor matches them.
`timescale 1ns/1ps

module tb_lcd_frame_scheduler;
  localparam int COORD_W     = 9;
  localparam int FRAME_DIV   = 100;
  localparam int TIMEOUT_CYC = 1000;
  localparam int PH_OFF = 0, PH_IDLE = 1, PH_PIC = 2, PH_LINE = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               init_done = 1'b0;
  logic [COORD_W-1:0] ball_y = 9'd0;
  logic [COORD_W-1:0] hand_x = 9'd0;
  logic               show_pic_done = 1'b0;
  logic               draw_line_done = 1'b0;
  logic               show_pic_flag, draw_line_flag, busy, timeout_err;
  logic [COORD_W-1:0] offset_lat, coord_lat;
  logic [15:0]        frame_cnt;

  lcd_frame_scheduler #(.COORD_W(COORD_W), .FRAME_DIV(FRAME_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .sys_clk_50MHz(clk), .sys_rst_n(rst_n), .init_done(init_done),
    .ball_y(ball_y), .hand_x(hand_x),
    .show_pic_done(show_pic_done), .draw_line_done(draw_line_done),
    .show_pic_flag(show_pic_flag), .draw_line_flag(draw_line_flag),
    .offset_lat(offset_lat), .coord_lat(coord_lat),
    .busy(busy), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int n; int b; int h; } start_t;
  typedef struct { int n; int fc; } done_t;
  start_t q_start[$];
  done_t  q_done[$];
  int     q_line[$];
  int     q_to[$];

  int n_checks = 0, n_errors = 0;

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: phase plus timestamps of the last frame start and phase entry.
  int m_ph = PH_OFF, m_first = 0, m_pend = 1, m_last = -1000000, m_ph_edge = 0;
  int m_lat_b = 0, m_lat_h = 0, m_fcnt = 0, m_terr = 0, m_delay = 1;
  int chg_rate = 0, no_resp = 0, fixed_delay = 0, rand_init = 0, init_low = 0;

  task automatic pick_delay();
    m_delay = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 8));
  endtask

  task automatic model_timeout(input int n);
    m_ph   = PH_IDLE;
    m_pend = 1;
    if (m_terr == 0) begin
      m_terr = 1;
      q_to.push_back(n);
    end
  endtask

  task automatic model_edge(input int n);
    bit diff;
    diff = (int'(ball_y) != m_lat_b) || (int'(hand_x) != m_lat_h);
    if (!init_done) begin
      if (m_ph != PH_OFF) begin
        m_ph   = PH_OFF;
        m_pend = 1;
      end
    end else begin
      case (m_ph)
        PH_OFF: begin
          m_ph = PH_IDLE; m_first = 1; m_pend = 1;
        end
        PH_IDLE: begin
          if ((m_first != 0 || (n - m_last) >= FRAME_DIV) && m_pend != 0) begin
            m_ph = PH_PIC; m_lat_b = int'(ball_y); m_lat_h = int'(hand_x);
            m_last = n; m_first = 0; m_pend = 0; m_ph_edge = n;
            pick_delay();
            q_start.push_back('{n, m_lat_b, m_lat_h});
          end else if (diff) m_pend = 1;
        end
        PH_PIC: begin
          if (diff) m_pend = 1;
          if (show_pic_done) begin
            m_ph = PH_LINE; m_ph_edge = n;
            pick_delay();
            q_line.push_back(n);
          end else if ((n - m_ph_edge) >= TIMEOUT_CYC) model_timeout(n);
        end
        PH_LINE: begin
          if (diff) m_pend = 1;
          if (draw_line_done) begin
            m_ph = PH_IDLE;
            m_fcnt = (m_fcnt + 1) % 65536;
            q_done.push_back('{n, m_fcnt});
          end else if ((n - m_ph_edge) >= TIMEOUT_CYC) model_timeout(n);
        end
        default: m_ph = PH_OFF;
      endcase
    end
  endtask

  // One cycle per iteration: inputs are set after a falling edge, then modelled for the next rising edge.
  task automatic step(input int k);
    int n;
    for (int i = 0; i < k; i++) begin
      n = cyc + 1;
      if (chg_rate != 0 && $urandom_range(0, chg_rate - 1) == 0) begin
        if ($urandom_range(0, 1) == 0) ball_y = 9'($urandom);
        else                            hand_x = 9'($urandom);
      end
      if (rand_init != 0) begin
        if (init_done && $urandom_range(0, 299) == 0) begin
          init_done = 1'b0;
          init_low  = int'($urandom_range(1, 5));
        end else if (!init_done) begin
          if (init_low == 0) init_done = 1'b1;
          else init_low--;
        end
      end
      if (m_ph == PH_PIC) show_pic_done = (no_resp == 0) && ((n - m_ph_edge) >= m_delay);
      else                show_pic_done = ($urandom_range(0, 15) == 0);
      if (m_ph == PH_LINE) draw_line_done = (no_resp == 0) && ((n - m_ph_edge) >= m_delay);
      else                 draw_line_done = ($urandom_range(0, 15) == 0);
      model_edge(n);
      @(negedge clk);
    end
  endtask

  // Monitor: pops expected events when the DUT shows them; flags late or spurious ones.
  bit     mon_en = 1'b0;
  logic   prev_spf = 1'b0, prev_dlf = 1'b0, prev_terr = 1'b0;
  logic [15:0] prev_fc = 16'd0;
  start_t mon_s;
  done_t  mon_d;
  int     mon_n;
  always @(negedge clk) begin
    if (mon_en) begin
      check("flags_exclusive", int'(show_pic_flag & draw_line_flag), 0);
      check("busy_vs_flags", int'(busy), int'(show_pic_flag | draw_line_flag));
      if (q_start.size() > 0 && q_start[0].n < cyc) begin
        mon_s = q_start.pop_front();
        check("start_missed_at", cyc, mon_s.n);
      end
      if (q_line.size() > 0 && q_line[0] < cyc) begin
        mon_n = q_line.pop_front();
        check("line_missed_at", cyc, mon_n);
      end
      if (q_done.size() > 0 && q_done[0].n < cyc) begin
        mon_d = q_done.pop_front();
        check("done_missed_at", cyc, mon_d.n);
      end
      if (q_to.size() > 0 && q_to[0] < cyc) begin
        mon_n = q_to.pop_front();
        check("timeout_missed_at", cyc, mon_n);
      end
      if (show_pic_flag && !prev_spf) begin
        if (q_start.size() == 0) check("unexpected_frame_start", cyc, -1);
        else begin
          mon_s = q_start.pop_front();
          check("start_cycle", cyc, mon_s.n);
          check("offset_lat", int'(offset_lat), mon_s.b);
          check("coord_lat", int'(coord_lat), mon_s.h);
        end
      end
      if (draw_line_flag && !prev_dlf) begin
        if (q_line.size() == 0) check("unexpected_line_phase", cyc, -1);
        else begin
          mon_n = q_line.pop_front();
          check("line_cycle", cyc, mon_n);
        end
      end
      if (frame_cnt != prev_fc) begin
        if (q_done.size() == 0) check("unexpected_frame_cnt", int'(frame_cnt), int'(prev_fc));
        else begin
          mon_d = q_done.pop_front();
          check("done_cycle", cyc, mon_d.n);
          check("frame_cnt", int'(frame_cnt), mon_d.fc);
        end
      end
      if (timeout_err != prev_terr) begin
        if (q_to.size() == 0) check("unexpected_timeout_err", int'(timeout_err), int'(prev_terr));
        else begin
          mon_n = q_to.pop_front();
          check("timeout_cycle", cyc, mon_n);
        end
      end
    end
    prev_spf  <= show_pic_flag;
    prev_dlf  <= draw_line_flag;
    prev_fc   <= frame_cnt;
    prev_terr <= timeout_err;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_show_pic_flag"}, int'(show_pic_flag), 0);
    check({tag, "_draw_line_flag"}, int'(draw_line_flag), 0);
    check({tag, "_offset_lat"}, int'(offset_lat), 0);
    check({tag, "_coord_lat"}, int'(coord_lat), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  int e0, guard;

  initial begin
    ball_y = 9'd5;
    hand_x = 9'd7;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Panel not ready: nothing may start. Then startup frame with (5,7).
    step(5);
    init_done = 1'b1;
    step(40);

    // Static coordinates: no further frames.
    step(1000);

    // Rate limit: change at +10 after a start, next start exactly FRAME_DIV later.
    hand_x = 9'd8;
    e0 = m_last; guard = 0;
    while (m_last == e0 && guard < 500) begin step(1); guard++; end
    check("rate_setup_started", int'(m_last != e0), 1);
    e0 = m_last;
    while (cyc + 1 < e0 + 10) step(1);
    hand_x = 9'd20;
    step(200);

    // Randomized coordinates and done latencies.
    chg_rate = 30;
    step(2000);
    chg_rate = 0;
    step(150);

    // Done exactly at the watchdog limit wins, then a genuine timeout with retry.
    fixed_delay = TIMEOUT_CYC;
    ball_y = ball_y ^ 9'd1;
    step(2300);
    fixed_delay = 0;
    no_resp = 1;
    hand_x = hand_x ^ 9'd1;
    step(1200);
    no_resp = 0;
    step(60);

    // Init loss during the line phase, then recovery with an immediate frame.
    hand_x = hand_x ^ 9'd2;
    guard = 0;
    while (m_ph != PH_LINE && guard < 500) begin step(1); guard++; end
    check("init_loss_reached_line", m_ph, PH_LINE);
    init_done = 1'b0;
    step(1);
    check("init_loss_show_pic_flag", int'(show_pic_flag), 0);
    check("init_loss_draw_line_flag", int'(draw_line_flag), 0);
    check("init_loss_busy", int'(busy), 0);
    check("init_loss_frame_cnt", int'(frame_cnt), m_fcnt);
    step(3);
    init_done = 1'b1;
    step(20);

    // Random coordinates with occasional init drops.
    chg_rate = 40;
    rand_init = 1;
    step(3000);
    rand_init = 0;
    chg_rate = 0;
    init_done = 1'b1;
    step(150);

    // Asynchronous reset in the middle of a frame clears outputs without a clock.
    ball_y = ball_y ^ 9'd4;
    guard = 0;
    while (!(m_ph == PH_PIC || m_ph == PH_LINE) && guard < 500) begin step(1); guard++; end
    #1;
    check("midframe_busy", int'(busy), 1);
    check("q_start_empty", q_start.size(), 0);
    check("q_line_empty", q_line.size(), 0);
    check("q_done_empty", q_done.size(), 0);
    check("q_to_empty", q_to.size(), 0);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_show_pic_flag", int'(show_pic_flag), 0);
    check("async_rst_draw_line_flag", int'(draw_line_flag), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_frame_cnt", int'(frame_cnt), 0);
    check("async_rst_timeout_err", int'(timeout_err), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
